fc_argmax_detect: RTL

FC_ARGMAX_DETECT -- requirements
Module: fc_argmax_detect

---
 rtl/fc_argmax_detect.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fc_argmax_detect.sv
// fc_argmax_detect
//   Scans a captured score vector one element per clock, reports the
//   argmax class and its score, and declares a keyword once the same
//   non-silence class has won with a score at or above THRESHOLD for
//   HOLD_FRAMES consecutive frames.
//
// Ports
//   clk            : sole clock, rising edge
//   rst            : asynchronous reset, active low
//   data_in        : score vector, element k at [k*ACTIV_BITS +: ACTIV_BITS]
//   data_valid     : single-cycle frame strobe
//   ready          : high while idle (a new frame can be accepted)
//   class_idx      : argmax index of the last completed frame
//   max_score      : score at class_idx
//   result_valid   : one-cycle pulse marking a new class_idx/max_score
//   keyword_detect : one-cycle pulse when a keyword is declared
//   keyword_id     : class of the last declared keyword
//   overrun        : one-cycle pulse after a strobe arrived while busy
module fc_argmax_detect #(
    parameter int NUM_CLASSES = 64,
    parameter int ACTIV_BITS = 16,
    parameter logic signed [ACTIV_BITS-1:0] THRESHOLD = 16'sd256,
    parameter int HOLD_FRAMES = 3,
    parameter int SILENCE_CLASS = 0,
    localparam int IDX_W = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in,
    input  logic                              data_valid,
    output logic                              ready,
    output logic [IDX_W-1:0]                  class_idx,
    output logic [ACTIV_BITS-1:0]             max_score,
    output logic                              result_valid,
    output logic                              keyword_detect,
    output logic [IDX_W-1:0]                  keyword_id,
    output logic                              overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] SIL_IDX  = IDX_W'(SILENCE_CLASS);
    localparam logic [3:0]       HOLD     = 4'(HOLD_FRAMES);

    state_t                  state_q;
    logic [ACTIV_BITS-1:0]   frame_q [NUM_CLASSES];
    logic [IDX_W-1:0]        scan_idx_q;
    logic [IDX_W-1:0]        run_idx_q;
    logic [ACTIV_BITS-1:0]   run_max_q;
    logic [IDX_W-1:0]        class_idx_q;
    logic [ACTIV_BITS-1:0]   max_score_q;
    logic                    result_valid_q;
    logic                    keyword_detect_q;
    logic [IDX_W-1:0]        keyword_id_q;
    logic                    overrun_q;
    logic [3:0]              hit_cnt_q;
    logic [3:0]              hit_cnt_d;
    logic [IDX_W-1:0]        last_class_q;

    logic signed [ACTIV_BITS-1:0] elem;
    logic                         hit;
    logic                         same_class;
    logic                         fire;

    // Hit evaluation works on the running result, which in DECIDE is the
    // final argmax of the frame about to be published.
    always_comb begin
        elem       = $signed(frame_q[scan_idx_q]);
        hit        = ($signed(run_max_q) >= THRESHOLD) && (run_idx_q != SIL_IDX);
        same_class = (run_idx_q == last_class_q);
        hit_cnt_d  = '0;
        fire       = 1'b0;
        if (hit) begin
            if (same_class) begin
                hit_cnt_d = (hit_cnt_q < HOLD) ? hit_cnt_q + 4'd1 : hit_cnt_q;
            end else begin
                hit_cnt_d = 4'd1;
            end
            // Fire only on arrival at HOLD; a saturated count for the same
            // class is already declared.
            fire = (hit_cnt_d == HOLD) && !(same_class && (hit_cnt_q == HOLD));
        end
    end

    // Frame storage needs no reset: it is only read after a capture.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && data_valid) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                frame_q[k] <= data_in[k*ACTIV_BITS +: ACTIV_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            scan_idx_q       <= '0;
            run_idx_q        <= '0;
            run_max_q        <= '0;
            class_idx_q      <= '0;
            max_score_q      <= '0;
            result_valid_q   <= 1'b0;
            keyword_detect_q <= 1'b0;
            keyword_id_q     <= '0;
            overrun_q        <= 1'b0;
            hit_cnt_q        <= '0;
            last_class_q     <= '0;
        end else begin
            result_valid_q   <= 1'b0;
            keyword_detect_q <= 1'b0;
            overrun_q        <= data_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        state_q    <= SCAN;
                        scan_idx_q <= '0;
                    end
                end
                SCAN: begin
                    // Strictly greater keeps the lowest index on ties.
                    if ((scan_idx_q == '0) || (elem > $signed(run_max_q))) begin
                        run_max_q <= elem;
                        run_idx_q <= scan_idx_q;
                    end
                    if (scan_idx_q == LAST_IDX) begin
                        state_q <= DECIDE;
                    end else begin
                        scan_idx_q <= scan_idx_q + IDX_W'(1);
                    end
                end
                DECIDE: begin
                    state_q        <= IDLE;
                    result_valid_q <= 1'b1;
                    class_idx_q    <= run_idx_q;
                    max_score_q    <= run_max_q;
                    hit_cnt_q      <= hit_cnt_d;
                    if (hit) begin
                        last_class_q <= run_idx_q;
                    end
                    if (fire) begin
                        keyword_detect_q <= 1'b1;
                        keyword_id_q     <= run_idx_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready          = (state_q == IDLE);
    assign class_idx      = class_idx_q;
    assign max_score      = max_score_q;
    assign result_valid   = result_valid_q;
    assign keyword_detect = keyword_detect_q;
    assign keyword_id     = keyword_id_q;
    assign overrun        = overrun_q;

endmodule
